// File: rtl/seg_scan4.sv
// Four-digit multiplexed seven-segment scanner with frame-synchronous shadow update,
// per-digit decimal points, optional leading-zero blanking and a frame-complete strobe.
module seg_scan4 #(
    parameter int unsigned DWELL      = 4,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic        load,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_out,
    output logic        frame_done
);

    localparam logic [7:0] CntLast = 8'(DWELL - 1);
    localparam logic [3:0] AnOff   = {4{ACTIVE_LOW}};
    localparam logic [6:0] SegOff  = {7{ACTIVE_LOW}};

    // Scan position and load path state
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] stg_val_q, stg_val_d;
    logic [3:0]  stg_dp_q, stg_dp_d;
    logic        pend_q, pend_d;
    logic [15:0] shd_val_q, shd_val_d;
    logic [3:0]  shd_dp_q, shd_dp_d;
    logic        bnd_q;

    // Registered, polarity-adjusted outputs
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic        fd_q;

    logic        last_dwell;
    logic        boundary;
    logic [3:0]  nib [4];
    logic [3:0]  nib_sel;
    logic [3:0]  lz_run;
    logic        blank;
    logic [3:0]  an_raw;
    logic [6:0]  seg_raw;
    logic        dp_raw;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b0111111;
            4'h1:    s = 7'b0000110;
            4'h2:    s = 7'b1011011;
            4'h3:    s = 7'b1001111;
            4'h4:    s = 7'b1100110;
            4'h5:    s = 7'b1101101;
            4'h6:    s = 7'b1111101;
            4'h7:    s = 7'b0000111;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1101111;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b1111100;
            4'hC:    s = 7'b0111001;
            4'hD:    s = 7'b1011110;
            4'hE:    s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

    // Scan counters and the staging/shadow handoff at the frame boundary
    always_comb begin
        last_dwell = (cnt_q == CntLast);
        boundary   = last_dwell && (idx_q == 2'd3);
        cnt_d      = last_dwell ? 8'd0 : cnt_q + 8'd1;
        idx_d      = last_dwell ? idx_q + 2'd1 : idx_q;
        stg_val_d  = stg_val_q;
        stg_dp_d   = stg_dp_q;
        pend_d     = pend_q;
        shd_val_d  = shd_val_q;
        shd_dp_d   = shd_dp_q;
        if (load) begin
            stg_val_d = value;
            stg_dp_d  = dp;
        end
        if (boundary) begin
            pend_d = 1'b0;
            // A load on the boundary edge bypasses staging so it costs no extra frame
            if (load) begin
                shd_val_d = value;
                shd_dp_d  = dp;
            end else if (pend_q) begin
                shd_val_d = stg_val_q;
                shd_dp_d  = stg_dp_q;
            end
        end else if (load) begin
            pend_d = 1'b1;
        end
    end

    // Digit decode with leading-zero blanking
    always_comb begin
        nib[0]    = shd_val_q[3:0];
        nib[1]    = shd_val_q[7:4];
        nib[2]    = shd_val_q[11:8];
        nib[3]    = shd_val_q[15:12];
        nib_sel   = nib[idx_q];
        lz_run[3] = (nib[3] == 4'h0);
        lz_run[2] = lz_run[3] && (nib[2] == 4'h0);
        lz_run[1] = lz_run[2] && (nib[1] == 4'h0);
        lz_run[0] = 1'b0;
        blank     = blank_lz && lz_run[idx_q];
        an_raw    = blank ? 4'b0000 : (4'b0001 << idx_q);
        seg_raw   = blank ? 7'b0000000 : hex_to_seg(nib_sel);
        dp_raw    = !blank && shd_dp_q[idx_q];
        an_d      = an_raw ^ AnOff;
        seg_d     = seg_raw ^ SegOff;
        dp_d      = dp_raw ^ ACTIVE_LOW;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q     <= 2'd0;
            cnt_q     <= 8'd0;
            stg_val_q <= 16'h0000;
            stg_dp_q  <= 4'h0;
            pend_q    <= 1'b0;
            shd_val_q <= 16'h0000;
            shd_dp_q  <= 4'h0;
            bnd_q     <= 1'b0;
            an_q      <= AnOff;
            seg_q     <= SegOff;
            dp_q      <= ACTIVE_LOW;
            fd_q      <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            stg_val_q <= stg_val_d;
            stg_dp_q  <= stg_dp_d;
            pend_q    <= pend_d;
            shd_val_q <= shd_val_d;
            shd_dp_q  <= shd_dp_d;
            bnd_q     <= boundary;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            // Delayed one stage so the strobe lines up with the first lit digit of the new frame
            fd_q      <= bnd_q;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp_out     = dp_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan4.sv
// Scoreboard bench for seg_scan4: expected per-cycle display states are queued when
// stimulus is driven and popped/compared one entry per scan clock.
module tb_seg_scan4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, load, blank_lz;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_out, frame_done;

    logic        reset1, load1, blank_lz1;
    logic [15:0] value1;
    logic [3:0]  dp1;
    logic [3:0]  an1;
    logic [6:0]  seg1;
    logic        dp_out1, frame_done1;

    seg_scan4 #(.DWELL(2), .ACTIVE_LOW(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .dp         (dp),
        .load       (load),
        .blank_lz   (blank_lz),
        .an         (an),
        .seg        (seg),
        .dp_out     (dp_out),
        .frame_done (frame_done)
    );

    seg_scan4 #(.DWELL(1), .ACTIVE_LOW(1'b1)) dut1 (
        .clk        (clk),
        .reset      (reset1),
        .value      (value1),
        .dp         (dp1),
        .load       (load1),
        .blank_lz   (blank_lz1),
        .an         (an1),
        .seg        (seg1),
        .dp_out     (dp_out1),
        .frame_done (frame_done1)
    );

    typedef struct {
        bit         sel;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    function automatic logic [6:0] seg_code(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b0111111;
            4'h1:    s = 7'b0000110;
            4'h2:    s = 7'b1011011;
            4'h3:    s = 7'b1001111;
            4'h4:    s = 7'b1100110;
            4'h5:    s = 7'b1101101;
            4'h6:    s = 7'b1111101;
            4'h7:    s = 7'b0000111;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1101111;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b1111100;
            4'hC:    s = 7'b0111001;
            4'hD:    s = 7'b1011110;
            4'hE:    s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic push_reset(input bit sel);
        exp_t e;
        e.sel = sel;
        e.an  = 4'hF;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        e.fd  = 1'b0;
        sb.push_back(e);
    endtask

    // Queue the first n cycles of a frame showing v/d (active-low board)
    task automatic push_frame(input bit sel, input int dwell, input logic [15:0] v,
                              input logic [3:0] d, input bit blz, input bit fd0, input int n);
        int pushed = 0;
        for (int k = 0; k < 4; k++) begin
            bit         blank = 1'b0;
            logic [3:0] onehot;
            if (blz && k > 0) begin
                blank = 1'b1;
                for (int j = k; j < 4; j++) if (v[4*j +: 4] != 4'h0) blank = 1'b0;
            end
            onehot = 4'b0001 << k;
            for (int c = 0; c < dwell; c++) begin
                if (pushed < n) begin
                    exp_t e;
                    e.sel = sel;
                    e.an  = blank ? 4'hF : ~onehot;
                    e.seg = blank ? 7'h7F : ~seg_code(v[4*k +: 4]);
                    e.dp  = blank ? 1'b1 : ~d[k];
                    e.fd  = (k == 0 && c == 0) ? fd0 : 1'b0;
                    sb.push_back(e);
                    pushed++;
                end
            end
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_underflow cyc=%0d got=empty want=entry", cyc);
        end else begin
            e = sb.pop_front();
            if (e.sel) begin
                check_eq($sformatf("an1@%0d", cyc), 32'(an1), 32'(e.an));
                check_eq($sformatf("seg1@%0d", cyc), 32'(seg1), 32'(e.seg));
                check_eq($sformatf("dp1@%0d", cyc), 32'(dp_out1), 32'(e.dp));
                check_eq($sformatf("fd1@%0d", cyc), 32'(frame_done1), 32'(e.fd));
            end else begin
                check_eq($sformatf("an@%0d", cyc), 32'(an), 32'(e.an));
                check_eq($sformatf("seg@%0d", cyc), 32'(seg), 32'(e.seg));
                check_eq($sformatf("dp@%0d", cyc), 32'(dp_out), 32'(e.dp));
                check_eq($sformatf("fd@%0d", cyc), 32'(frame_done), 32'(e.fd));
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        load      = 1'b0;
        blank_lz  = 1'b0;
        value     = 16'h0000;
        dp        = 4'h0;
        reset1    = 1'b1;
        load1     = 1'b0;
        blank_lz1 = 1'b0;
        value1    = 16'h0000;
        dp1       = 4'h0;

        // Reset held three cycles
        repeat (3) push_reset(1'b0);
        repeat (3) tick();
        reset = 1'b0;

        // Frame 0: zeros; load 0x1234 while digit 1 is lit, must not tear this frame
        push_frame(1'b0, 2, 16'h0000, 4'h0, 1'b0, 1'b0, 8);
        for (int i = 1; i <= 8; i++) begin
            if (i == 4) begin
                load = 1'b1; value = 16'h1234; dp = 4'b0100;
            end
            tick();
            load = 1'b0;
        end

        // Frame 1: 0x1234; two loads, last one wins
        push_frame(1'b0, 2, 16'h1234, 4'b0100, 1'b0, 1'b1, 8);
        for (int i = 9; i <= 16; i++) begin
            if (i == 10) begin
                load = 1'b1; value = 16'hAAAA; dp = 4'b1111;
            end
            if (i == 13) begin
                load = 1'b1; value = 16'h00F0; dp = 4'b0000;
            end
            tick();
            load = 1'b0;
        end

        // Frame 2: 0x00F0; load on the boundary edge goes straight to the display
        push_frame(1'b0, 2, 16'h00F0, 4'h0, 1'b0, 1'b1, 8);
        for (int i = 17; i <= 24; i++) begin
            if (i == 24) begin
                load = 1'b1; value = 16'h0070; dp = 4'b0000;
            end
            tick();
            load = 1'b0;
        end
        blank_lz = 1'b1;

        // Frame 3: 0x0070 with blanking; queue an all-zero value with a dp on a blanked digit
        push_frame(1'b0, 2, 16'h0070, 4'h0, 1'b1, 1'b1, 8);
        for (int i = 25; i <= 32; i++) begin
            if (i == 28) begin
                load = 1'b1; value = 16'h0000; dp = 4'b0010;
            end
            tick();
            load = 1'b0;
        end

        // Frame 4: only digit 0 lit; load during digit 2, then reset (with load still high)
        push_frame(1'b0, 2, 16'h0000, 4'b0010, 1'b1, 1'b1, 5);
        for (int i = 33; i <= 37; i++) begin
            if (i == 37) begin
                load = 1'b1; value = 16'hBEEF; dp = 4'b1111;
            end
            tick();
            if (i < 37) load = 1'b0;
        end
        reset = 1'b1;
        push_reset(1'b0);
        tick();
        reset = 1'b0;
        load  = 1'b0;

        // Two frames after reset: discarded load must never appear
        push_frame(1'b0, 2, 16'h0000, 4'h0, 1'b1, 1'b0, 8);
        push_frame(1'b0, 2, 16'h0000, 4'h0, 1'b1, 1'b1, 8);
        repeat (16) tick();

        // DWELL=1 instance
        push_reset(1'b1);
        tick();
        reset1 = 1'b0;
        push_frame(1'b1, 1, 16'h0000, 4'h0, 1'b0, 1'b0, 4);
        push_frame(1'b1, 1, 16'h9A3C, 4'b0001, 1'b0, 1'b1, 4);
        push_frame(1'b1, 1, 16'h9A3C, 4'b0001, 1'b0, 1'b1, 4);
        for (int i = 1; i <= 12; i++) begin
            if (i == 2) begin
                load1 = 1'b1; value1 = 16'h9A3C; dp1 = 4'b0001;
            end
            tick();
            load1 = 1'b0;
        end

        check_eq("sb_drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
